// File: rtl/traffic_light_pkg.sv
// Shared light encoding, monitor fault/state types, and the single definition of the legal light order.
// The generator and the monitor both use next_light() so they cannot disagree on sequencing.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } trafic_light_t;

    typedef enum logic [1:0] {
        F_NONE    = 2'b00,
        F_ILLEGAL = 2'b01,
        F_INVALID = 2'b10,
        F_STUCK   = 2'b11
    } fault_code_t;

    typedef enum logic [1:0] {
        ARMING = 2'b00,
        TRACK  = 2'b01,
        FAULT  = 2'b10
    } monitor_state_t;

    function automatic trafic_light_t next_light(input trafic_light_t cur);
        trafic_light_t nxt;
        case (cur)
            GREEN:   nxt = YELLOW;
            YELLOW:  nxt = RED;
            RED:     nxt = GREEN;
            default: nxt = GREEN;
        endcase
        return nxt;
    endfunction

    function automatic logic light_is_valid(input trafic_light_t t);
        return (t == GREEN) || (t == YELLOW) || (t == RED);
    endfunction

endpackage

// File: rtl/light_dwell_counter.sv
// Saturating phase-dwell counter: clear has priority over increment, one-cycle update latency.
// No backpressure; at_max flags the all-ones value where increments stop.
module light_dwell_counter #(
    parameter int DW_W = 8
) (
    input  logic            clk,
    input  logic            asyn_n_reset,
    input  logic            clr,
    input  logic            inc,
    output logic [DW_W-1:0] cnt,
    output logic            at_max
);

    logic [DW_W-1:0] cnt_q;
    logic [DW_W-1:0] cnt_d;

    assign at_max = &cnt_q;
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + DW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge asyn_n_reset) begin
        if (!asyn_n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// In-design checker of the GREEN->YELLOW->RED order: latches the first fault, pulses every fault event.
// All outputs registered, one edge after the offending sample; pure observer, never backpressures.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int MAX_DWELL = 16,
    parameter int DW_W      = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             asyn_n_reset,
    input  trafic_light_t    tf_in,
    input  logic             clr_fault,
    output logic             fault,
    output fault_code_t      fault_code,
    output logic             illegal_pulse,
    output logic [DW_W-1:0]  dwell,
    output logic [CNT_W-1:0] cycle_cnt
);

    monitor_state_t   state_q, state_d;
    trafic_light_t    prev_q, prev_d;
    logic             fault_q, fault_d;
    fault_code_t      code_q, code_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             dw_clr, dw_inc, dw_at_max;
    logic [DW_W-1:0]  dw_cnt;

    logic             hold, legal, ev_invalid, ev_illegal, ev_stuck;
    fault_code_t      ev_code;

    light_dwell_counter #(
        .DW_W(DW_W)
    ) u_dwell (
        .clk         (clk),
        .asyn_n_reset(asyn_n_reset),
        .clr         (dw_clr),
        .inc         (dw_inc),
        .cnt         (dw_cnt),
        .at_max      (dw_at_max)
    );

    // A prev_tf that is itself invalid (only reachable in FAULT) never makes a change illegal.
    always_comb begin
        hold       = (tf_in == prev_q);
        legal      = !hold && light_is_valid(tf_in) && light_is_valid(prev_q)
                     && (tf_in == next_light(prev_q));
        ev_invalid = !hold && !light_is_valid(tf_in);
        ev_illegal = !hold && light_is_valid(tf_in) && light_is_valid(prev_q) && !legal;
        ev_stuck   = hold && !dw_at_max && ((dw_cnt + DW_W'(1)) == DW_W'(MAX_DWELL));
        if (ev_invalid)      ev_code = F_INVALID;
        else if (ev_illegal) ev_code = F_ILLEGAL;
        else if (ev_stuck)   ev_code = F_STUCK;
        else                 ev_code = F_NONE;
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        fault_d = fault_q;
        code_d  = code_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        dw_clr  = 1'b0;
        dw_inc  = 1'b0;
        case (state_q)
            ARMING: begin
                prev_d = tf_in;
                dw_clr = 1'b1;
                if (!light_is_valid(tf_in)) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    code_d  = F_INVALID;
                    pulse_d = 1'b1;
                end else begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (hold) begin
                    dw_inc = 1'b1;
                end else begin
                    prev_d = tf_in;
                    dw_clr = 1'b1;
                end
                if (ev_code != F_NONE) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    code_d  = ev_code;
                    pulse_d = 1'b1;
                end else if (legal && (prev_q == RED)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FAULT: begin
                // Clear beats any violation seen on the same edge; ARMING re-samples next.
                if (clr_fault) begin
                    state_d = ARMING;
                    fault_d = 1'b0;
                    code_d  = F_NONE;
                    dw_clr  = 1'b1;
                end else begin
                    if (hold) begin
                        dw_inc = 1'b1;
                    end else begin
                        prev_d = tf_in;
                        dw_clr = 1'b1;
                    end
                    pulse_d = (ev_code != F_NONE);
                end
            end
            default: begin
                state_d = ARMING;
            end
        endcase
    end

    always_ff @(posedge clk or negedge asyn_n_reset) begin
        if (!asyn_n_reset) begin
            state_q <= ARMING;
            prev_q  <= GREEN;
            fault_q <= 1'b0;
            code_q  <= F_NONE;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fault         = fault_q;
    assign fault_code    = code_q;
    assign illegal_pulse = pulse_q;
    assign dwell         = dw_cnt;
    assign cycle_cnt     = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;
    import traffic_light_pkg::*;

    logic          clk = 1'b0;
    logic          asyn_n_reset = 1'b0;
    trafic_light_t tf_in = GREEN;
    logic          clr_fault = 1'b0;
    logic          fault;
    fault_code_t   fault_code;
    logic          illegal_pulse;
    logic [7:0]    dwell;
    logic [3:0]    cycle_cnt;

    int n_checks = 0;
    int n_errors = 0;

    traffic_light_monitor #(
        .MAX_DWELL(16),
        .DW_W     (8),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .asyn_n_reset (asyn_n_reset),
        .tf_in        (tf_in),
        .clr_fault    (clr_fault),
        .fault        (fault),
        .fault_code   (fault_code),
        .illegal_pulse(illegal_pulse),
        .dwell        (dwell),
        .cycle_cnt    (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input trafic_light_t tf, input logic clr);
        tf_in     = tf;
        clr_fault = clr;
        @(posedge clk);
        #1;
        clr_fault = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic f, input fault_code_t c, input logic p);
        chk({tag, ".fault"}, 32'(fault), 32'(f));
        chk({tag, ".code"},  32'(fault_code), 32'(c));
        chk({tag, ".pulse"}, 32'(illegal_pulse), 32'(p));
    endtask

    initial begin
        // Reset values
        #2;
        chk_status("reset", 1'b0, F_NONE, 1'b0);
        chk("reset.dwell", 32'(dwell), 32'd0);
        chk("reset.cnt", 32'(cycle_cnt), 32'd0);
        #10 asyn_n_reset = 1'b1;

        // Live G,Y,R stream: arm on GREEN then ten full cycles
        step(GREEN, 1'b0);
        chk("live.arm.dwell", 32'(dwell), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(YELLOW, 1'b0);
            chk("live.fault", 32'(fault), 32'd0);
            chk("live.dwell", 32'(dwell), 32'd0);
            step(RED, 1'b0);
            chk("live.fault", 32'(fault), 32'd0);
            step(GREEN, 1'b0);
            chk("live.dwell", 32'(dwell), 32'd0);
        end
        chk("live.cnt", 32'(cycle_cnt), 32'd10);

        // Illegal G->R, then events while in FAULT
        step(RED, 1'b0);
        chk_status("ill.g2r", 1'b1, F_ILLEGAL, 1'b1);
        chk("ill.g2r.cnt", 32'(cycle_cnt), 32'd10);
        step(RED, 1'b0);
        chk_status("ill.hold", 1'b1, F_ILLEGAL, 1'b0);
        chk("ill.hold.dwell", 32'(dwell), 32'd1);
        step(YELLOW, 1'b0);
        chk_status("ill.r2y", 1'b1, F_ILLEGAL, 1'b1);
        step(RED, 1'b0);
        chk_status("ill.y2r", 1'b1, F_ILLEGAL, 1'b0);
        step(GREEN, 1'b0);
        chk("ill.frozen_cnt", 32'(cycle_cnt), 32'd10);
        chk("ill.r2g.pulse", 32'(illegal_pulse), 32'd0);

        // Clear coinciding with a violation: clear wins, ARMING samples without check
        step(RED, 1'b1);
        chk_status("clr.win", 1'b0, F_NONE, 1'b0);
        chk("clr.win.dwell", 32'(dwell), 32'd0);
        step(RED, 1'b0);
        chk_status("clr.arm", 1'b0, F_NONE, 1'b0);
        step(GREEN, 1'b0);
        chk("clr.resume_cnt", 32'(cycle_cnt), 32'd11);
        step(GREEN, 1'b1);
        chk("clr.track_noeffect.dwell", 32'(dwell), 32'd1);
        chk("clr.track_noeffect.fault", 32'(fault), 32'd0);

        // STUCK: legal G->Y then 16 YELLOW holds
        step(YELLOW, 1'b0);
        for (int i = 1; i <= 15; i++) step(YELLOW, 1'b0);
        chk("stuck.pre.dwell", 32'(dwell), 32'd15);
        chk("stuck.pre.fault", 32'(fault), 32'd0);
        step(YELLOW, 1'b0);
        chk_status("stuck.hit", 1'b1, F_STUCK, 1'b1);
        chk("stuck.hit.dwell", 32'(dwell), 32'd16);
        step(YELLOW, 1'b0);
        chk("stuck.after.dwell", 32'(dwell), 32'd17);
        chk("stuck.after.pulse", 32'(illegal_pulse), 32'd0);
        for (int i = 0; i < 238; i++) step(YELLOW, 1'b0);
        chk("stuck.sat.dwell", 32'(dwell), 32'd255);
        step(YELLOW, 1'b0);
        chk("stuck.sat2.dwell", 32'(dwell), 32'd255);
        chk_status("stuck.sat2", 1'b1, F_STUCK, 1'b0);

        // INVALID while GREEN
        step(YELLOW, 1'b1);
        step(GREEN, 1'b0);
        step(trafic_light_t'(2'b11), 1'b0);
        chk_status("inv.green", 1'b1, F_INVALID, 1'b1);

        // INVALID on the edge where a hold would have reached MAX_DWELL
        step(GREEN, 1'b1);
        step(GREEN, 1'b0);
        for (int i = 0; i < 15; i++) step(GREEN, 1'b0);
        chk("inv.pre.dwell", 32'(dwell), 32'd15);
        step(trafic_light_t'(2'b11), 1'b0);
        chk_status("inv.at_max", 1'b1, F_INVALID, 1'b1);

        // INVALID sampled during ARMING
        step(GREEN, 1'b1);
        step(trafic_light_t'(2'b11), 1'b0);
        chk_status("inv.arming", 1'b1, F_INVALID, 1'b1);

        // Build dwell=5, cycle_cnt=3, then async reset between edges
        #2 asyn_n_reset = 1'b0;
        #2 asyn_n_reset = 1'b1;
        step(GREEN, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(YELLOW, 1'b0);
            step(RED, 1'b0);
            step(GREEN, 1'b0);
        end
        for (int i = 0; i < 5; i++) step(GREEN, 1'b0);
        chk("rst.pre.dwell", 32'(dwell), 32'd5);
        chk("rst.pre.cnt", 32'(cycle_cnt), 32'd3);
        #2 asyn_n_reset = 1'b0;
        #1;
        chk_status("rst.async", 1'b0, F_NONE, 1'b0);
        chk("rst.async.dwell", 32'(dwell), 32'd0);
        chk("rst.async.cnt", 32'(cycle_cnt), 32'd0);
        #2 asyn_n_reset = 1'b1;
        step(RED, 1'b0);
        chk_status("rst.arm", 1'b0, F_NONE, 1'b0);
        step(GREEN, 1'b0);
        chk("rst.first_r2g.cnt", 32'(cycle_cnt), 32'd1);

        // Wrap of the 4-bit cycle counter
        for (int i = 0; i < 14; i++) begin
            step(YELLOW, 1'b0);
            step(RED, 1'b0);
            step(GREEN, 1'b0);
        end
        chk("wrap.pre.cnt", 32'(cycle_cnt), 32'd15);
        step(YELLOW, 1'b0);
        step(RED, 1'b0);
        step(GREEN, 1'b0);
        chk("wrap.cnt", 32'(cycle_cnt), 32'd0);
        chk("wrap.fault", 32'(fault), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
